instr_fetch_issue: RTL and testbench

- Instruction-side initiator that feeds the decoder.
- Fetches 32-bit instructions from a byte-wide instruction memory, four big-endian byte reads per word, opcode in the top byte.
- Presents each word on instruction_out with a one-cycle start pulse and waits for the decoder's ready before fetching the next word.
- Owns the program counter; supports redirect (branch/jump) and halt.

---
 rtl/instr_fetch_issue.sv | 123 ++++++++++++
 tb/tb_instr_fetch_issue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_issue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_issue
// Brief    : Fetches big-endian 32-bit instructions byte by byte, issues them
//            to the decoder with a start pulse and owns the program counter.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_issue #(
    parameter int                  BYTE_W      = 8,
    parameter int                  WIDTH_OUT   = 4 * BYTE_W,
    parameter int                  ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC    = '0,
    parameter logic [BYTE_W-1:0]   HALT_OPCODE = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [BYTE_W-1:0]    mem_data,
    input  logic                 mem_valid,
    output logic [WIDTH_OUT-1:0] instruction_out,
    output logic                 start,
    input  logic                 ready,
    input  logic                 redirect,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic [ADDR_W-1:0]    pc,
    output logic                 halted
);

    localparam logic [2:0]        c_ST_IDLE   = 3'd0;
    localparam logic [2:0]        c_ST_FETCH  = 3'd1;
    localparam logic [2:0]        c_ST_ISSUE  = 3'd2;
    localparam logic [2:0]        c_ST_WAIT   = 3'd3;
    localparam logic [2:0]        c_ST_HALTED = 3'd4;

    localparam logic [1:0]        c_LAST_BYTE  = 2'd3;
    localparam logic [ADDR_W-1:0] c_PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_ALIGN_MASK = ~ADDR_W'(3);

    logic [2:0]                r_state;
    logic [ADDR_W-1:0]         r_pc;
    logic [1:0]                r_byte_cnt;
    // Only the first three bytes need holding; the fourth arrives with mem_data.
    logic [WIDTH_OUT-BYTE_W-1:0] r_shift;
    logic [WIDTH_OUT-1:0]      r_instr;

    logic [WIDTH_OUT-1:0]      w_word;
    logic [BYTE_W-1:0]         w_opcode;
    logic [ADDR_W-1:0]         w_redirect_pc;
    logic [ADDR_W-1:0]         w_next_pc;

    assign w_word        = {r_shift, mem_data};
    assign w_opcode      = r_instr[WIDTH_OUT-1 -: BYTE_W];
    assign w_redirect_pc = redirect_pc & c_ALIGN_MASK;
    assign w_next_pc     = r_pc + c_PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_pc       <= RESET_PC;
            r_byte_cnt <= 2'd0;
            r_shift    <= '0;
            r_instr    <= '0;
        end else if (redirect) begin
            // Redirect beats every other event, including a halt-opcode accept.
            r_pc       <= w_redirect_pc;
            r_byte_cnt <= 2'd0;
            r_state    <= run ? c_ST_FETCH : c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (run) begin
                        r_state    <= c_ST_FETCH;
                        r_byte_cnt <= 2'd0;
                    end
                end
                c_ST_FETCH: begin
                    if (mem_valid) begin
                        r_shift    <= w_word[WIDTH_OUT-BYTE_W-1:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_instr <= w_word;
                            r_state <= c_ST_ISSUE;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (ready) begin
                        r_pc <= w_next_pc;
                        if (w_opcode == HALT_OPCODE) begin
                            r_state <= c_ST_HALTED;
                        end else if (run) begin
                            r_state <= c_ST_FETCH;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_HALTED: begin
                    r_state <= c_ST_HALTED;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state flops; start is masked by a
    // same-cycle redirect so an aborted issue is never seen by the decoder.
    assign mem_req         = (r_state == c_ST_FETCH);
    assign mem_addr        = r_pc + {{(ADDR_W-2){1'b0}}, r_byte_cnt};
    assign start           = (r_state == c_ST_ISSUE) && !redirect;
    assign halted          = (r_state == c_ST_HALTED);
    assign instruction_out = r_instr;
    assign pc              = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_issue
// Brief    : Self-checking bench for instr_fetch_issue against a byte-array
//            memory model and transaction-level expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_valid;
    logic [31:0] instruction_out;
    logic        start;
    logic        ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc;
    logic        halted;

    logic [7:0]  mem [0:65535];
    int          vectors = 0;
    int          fails   = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr];

    instr_fetch_issue dut (
        .clk             (clk),
        .rst             (rst),
        .run             (run),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_valid       (mem_valid),
        .instruction_out (instruction_out),
        .start           (start),
        .ready           (ready),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .pc              (pc),
        .halted          (halted)
    );

    function automatic logic [31:0] model_word(input logic [15:0] a);
        return {mem[a], mem[a + 16'd1], mem[a + 16'd2], mem[a + 16'd3]};
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one fetch from exp_pc until start; every accepted byte must come
    // from the next sequential address and the issued word must match memory.
    task automatic fetch_word(input logic [15:0] exp_pc, input bit stalls);
        int   n   = 0;
        bit   got = 1'b0;
        logic mv;
        for (int cyc = 0; cyc < 300 && !got; cyc++) begin
            if (start) begin
                got = 1'b1;
                chk("bytes_per_word", n, 4);
                chk("instr_word", instruction_out, model_word(exp_pc));
                chk("issue_pc", pc, exp_pc);
            end else begin
                mv = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mem_req && mv) begin
                    chk("byte_addr", mem_addr, exp_pc + 16'(n));
                    n++;
                end
                mem_valid = mv;
                step();
            end
        end
        vectors++;
        assert (got) else begin
            fails++;
            $error("FAIL fetch_timeout: observed no start expected start for pc %h", exp_pc);
        end
        mem_valid = 1'b1;
    endtask

    // From the ISSUE cycle: hold ready low for delay WAIT cycles, then accept.
    task automatic accept(input int delay);
        ready = 1'b0;
        step();
        chk("start_in_wait", start, 0);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("start_in_wait", start, 0);
        end
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rp;
        logic [15:0] exp_pc;

        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            if ((i % 4) == 0 && mem[i] == 8'hFF) mem[i] = 8'h00;
        end
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
        mem[4] = 8'hFF; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00;

        rst = 1'b1; run = 1'b0; mem_valid = 1'b0; ready = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0000;
        #2;
        chk("rst_instr", instruction_out, 32'h0);
        chk("rst_start", start, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_halted", halted, 0);
        chk("rst_pc", pc, 16'h0000);
        step();
        step();
        rst = 1'b0;
        run = 1'b1;
        mem_valid = 1'b1;
        step();

        // First FETCH cycle onward: four bytes, then start in the fifth cycle.
        for (int k = 0; k < 4; k++) begin
            chk("first_fetch_start", start, 0);
            chk("first_fetch_req", mem_req, 1);
            chk("first_fetch_addr", mem_addr, 16'(k));
            step();
        end
        chk("first_start", start, 1);
        chk("first_instr", instruction_out, 32'h12345678);
        chk("issue_req", mem_req, 0);
        step();
        chk("start_one_cycle", start, 0);
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("pc_after_ready", pc, 16'h0004);
        chk("refetch_req", mem_req, 1);
        chk("refetch_addr", mem_addr, 16'h0004);

        // Stall mem_valid for three cycles after the first byte.
        step();
        chk("stall_addr", mem_addr, 16'h0005);
        mem_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_hold_addr", mem_addr, 16'h0005);
            chk("stall_no_start", start, 0);
        end
        mem_valid = 1'b1;
        for (int k = 2; k < 4; k++) begin
            step();
            chk("stall_addr_next", mem_addr, 16'(4 + k));
        end
        step();
        chk("halt_word_start", start, 1);
        chk("halt_word", instruction_out, 32'hFF000000);
        accept(1);
        for (int k = 0; k < 20; k++) begin
            chk("halted", halted, 1);
            chk("halted_pc", pc, 16'h0008);
            chk("halted_req", mem_req, 0);
            step();
        end

        redirect = 1'b1;
        redirect_pc = 16'h0013;
        step();
        redirect = 1'b0;
        chk("redir_pc", pc, 16'h0010);
        chk("redir_halted", halted, 0);
        chk("redir_req", mem_req, 1);
        chk("redir_addr", mem_addr, 16'h0010);
        fetch_word(16'h0010, 1'b1);
        accept($urandom_range(0, 3));
        chk("pc_0x14", pc, 16'h0014);
        chk("addr_0x14", mem_addr, 16'h0014);

        // Redirect while the third byte is outstanding.
        mem_valid = 1'b1;
        step();
        chk("partial_addr1", mem_addr, 16'h0015);
        step();
        chk("partial_addr2", mem_addr, 16'h0016);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        chk("abort_start", start, 0);
        chk("abort_addr", mem_addr, 16'h0040);
        chk("abort_pc", pc, 16'h0040);
        fetch_word(16'h0040, 1'b1);

        // ready and redirect together in WAIT.
        ready = 1'b0;
        step();
        chk("wait_start", start, 0);
        ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 16'h0100;
        step();
        ready = 1'b0;
        redirect = 1'b0;
        chk("ready_redirect_pc", pc, 16'h0100);
        chk("ready_redirect_addr", mem_addr, 16'h0100);
        fetch_word(16'h0100, 1'b1);

        ready = 1'b0;
        step();
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("align_pc", pc, 16'hFFFC);
        fetch_word(16'hFFFC, 1'b1);
        accept(2);
        chk("pc_wrap", pc, 16'h0000);
        chk("pc_wrap_addr", mem_addr, 16'h0000);
        fetch_word(16'h0000, 1'b1);
        accept(0);
        chk("pc_after_wrap_word", pc, 16'h0004);
        fetch_word(16'h0004, 1'b1);

        // Reset in WAIT before the halt word is accepted.
        ready = 1'b0;
        step();
        rst = 1'b1;
        run = 1'b0;
        #1;
        chk("midrst_start", start, 0);
        chk("midrst_req", mem_req, 0);
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_instr", instruction_out, 32'h0);
        step();
        rst = 1'b0;
        mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("idle_req", mem_req, 0);
            chk("idle_addr", mem_addr, 16'h0000);
            chk("idle_halted", halted, 0);
        end
        run = 1'b1;
        step();
        chk("restart_req", mem_req, 1);
        chk("restart_addr", mem_addr, 16'h0000);

        // run dropped during FETCH: the word still completes and issues.
        run = 1'b0;
        fetch_word(16'h0000, 1'b1);
        accept(1);
        chk("run_low_pc", pc, 16'h0004);
        for (int k = 0; k < 3; k++) begin
            chk("run_low_idle", mem_req, 0);
            step();
        end

        run = 1'b1;
        for (int r = 0; r < 8; r++) begin
            rp = 16'($urandom) | 16'h1000;
            exp_pc = rp & 16'hFFFC;
            redirect = 1'b1;
            redirect_pc = rp;
            step();
            redirect = 1'b0;
            chk("rand_redir_pc", pc, exp_pc);
            fetch_word(exp_pc, 1'b1);
            accept($urandom_range(0, 3));
            chk("rand_next_pc", pc, exp_pc + 16'd4);
            chk("rand_next_req", mem_req, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire
